// File: rtl/trail_write_sched.sv
// trail_write_sched: frame-tick trail-pixel writer and bulk clear engine on a req/ack SRAM write port
// Ports: Clk/Reset (sync, active-high); frame_clk (async frame clock); Game_State; Blue_X/Y, Red_X/Y;
//        clear_req (pulse); mem_ack; mem_req/mem_addr/mem_data (write port); busy; clear_done; overrun
module trail_write_sched #(
    parameter int          ROW_WORDS  = 320,
    parameter int          X_OFFSET   = 8,
    parameter logic [2:0]  PLAY_STATE = 3'b010,
    parameter logic [15:0] BLUE_DATA  = 16'h0001,
    parameter logic [15:0] RED_DATA   = 16'h0003,
    parameter logic [19:0] CLEAR_BASE = 20'd0,
    parameter logic [19:0] CLEAR_LEN  = 20'd153600
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [2:0]  Game_State,
    input  logic [7:0]  Blue_X,
    input  logic [7:0]  Blue_Y,
    input  logic [7:0]  Red_X,
    input  logic [7:0]  Red_Y,
    input  logic        clear_req,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        busy,
    output logic        clear_done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, TRAIL, CLEAR} state_t;
    state_t      state, state_n;
    logic [2:0]  sync;
    logic [2:0]  idx, idx_n;
    logic [19:0] cnt, cnt_n;
    logic [7:0]  bx, by, rx, ry, bx_n, by_n, rx_n, ry_n;
    logic        pending, pending_n, clr_hold, clr_hold_n, overrun_n, done_n, start;
    logic        tick, ack, play;
    logic [7:0]  x, y;
    logic [19:0] base, addr_n;
    logic [15:0] data_n;
    // sync[1:0] is the synchronizer, sync[2] the edge register
    assign tick = sync[1] & ~sync[2];
    assign ack  = mem_req & mem_ack;
    assign play = Game_State == PLAY_STATE;
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        bx_n       = bx;
        by_n       = by;
        rx_n       = rx;
        ry_n       = ry;
        pending_n  = pending;
        clr_hold_n = clr_hold;
        overrun_n  = 1'b0;
        done_n     = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n   = CLEAR;
                    cnt_n     = 20'd0;
                    pending_n = 1'b0;
                    overrun_n = tick;
                end else if ((tick | pending) && play) begin
                    start = 1'b1;
                end
            end
            TRAIL: begin
                overrun_n  = tick & pending;
                pending_n  = pending | tick;
                clr_hold_n = clr_hold | clear_req;
                // exits are decided only on an accepted write so the handshake always completes
                if (ack) begin
                    if (clr_hold_n) begin
                        state_n    = CLEAR;
                        cnt_n      = 20'd0;
                        pending_n  = 1'b0;
                        clr_hold_n = 1'b0;
                    end else if (!play) begin
                        state_n   = IDLE;
                        pending_n = 1'b0;
                    end else if (idx == 3'd7) begin
                        if (pending_n) start = 1'b1;
                        else state_n = IDLE;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            CLEAR: begin
                overrun_n = tick;
                if (ack) begin
                    if (cnt == CLEAR_LEN - 20'd1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 20'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n   = TRAIL;
            idx_n     = 3'd0;
            pending_n = 1'b0;
            bx_n      = Blue_X;
            by_n      = Blue_Y;
            rx_n      = Red_X;
            ry_n      = Red_Y;
        end
    end
    // address/data are formed from next-state values so the port itself is purely registered
    assign x      = idx_n[2] ? rx_n : bx_n;
    assign y      = idx_n[2] ? ry_n : by_n;
    assign base   = 20'((20'(x) + 20'(X_OFFSET)) * 2) + 20'(y) * 20'(ROW_WORDS * 4);
    assign addr_n = state_n == CLEAR ? CLEAR_BASE + cnt_n :
                    state_n == TRAIL ? base + (idx_n[0] ? 20'(ROW_WORDS) : 20'd0) + {19'd0, idx_n[1]} : 20'd0;
    assign data_n = state_n == TRAIL ? (idx_n[2] ? RED_DATA : BLUE_DATA) : 16'h0000;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            sync       <= 3'd0;
            idx        <= 3'd0;
            cnt        <= 20'd0;
            bx         <= 8'd0;
            by         <= 8'd0;
            rx         <= 8'd0;
            ry         <= 8'd0;
            pending    <= 1'b0;
            clr_hold   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 20'd0;
            mem_data   <= 16'h0000;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            sync       <= {sync[1:0], frame_clk};
            idx        <= idx_n;
            cnt        <= cnt_n;
            bx         <= bx_n;
            by         <= by_n;
            rx         <= rx_n;
            ry         <= ry_n;
            pending    <= pending_n;
            clr_hold   <= clr_hold_n;
            mem_req    <= state_n != IDLE;
            mem_addr   <= addr_n;
            mem_data   <= data_n;
            busy       <= state_n != IDLE;
            clear_done <= done_n;
            overrun    <= overrun_n;
        end
    end
endmodule

// File: tb/tb_trail_write_sched.sv
// tb_trail_write_sched: scoreboard bench for trail_write_sched (CLEAR_LEN reduced to 16)
// Ports driven: all DUT inputs; observed: write port, busy, clear_done, overrun
module tb_trail_write_sched;
    logic        Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, clear_req = 1'b0, mem_ack = 1'b0;
    logic [2:0]  Game_State = 3'b000;
    logic [7:0]  Blue_X = 8'd0, Blue_Y = 8'd0, Red_X = 8'd0, Red_Y = 8'd0;
    logic        mem_req, busy, clear_done, overrun;
    logic [19:0] mem_addr;
    logic [15:0] mem_data;
    localparam logic [2:0] PLAY = 3'b010;
    int          vectors = 0, errors = 0, n_ovr = 0, n_done = 0;
    logic [35:0] sb[$];
    logic [35:0] e;
    trail_write_sched #(.CLEAR_LEN(20'd16)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .clear_req(clear_req), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .clear_done(clear_done), .overrun(overrun)
    );
    always #10 Clk = ~Clk;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (overrun === 1'b1) n_ovr++;
            if (clear_done === 1'b1) n_done++;
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got addr=%0d data=%h, expected no write", mem_addr, mem_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_data} !== e) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                                 mem_addr, mem_data, e[35:16], e[15:0]);
                    end
                end
            end
        end
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask
    task automatic wait_req(input string name);
        int n = 0;
        while (mem_req !== 1'b1 && n < 12) begin
            step(1);
            n++;
        end
        vectors++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout got mem_req=%b, expected 1 within 12 cycles", name, mem_req);
        end
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step(1);
            n++;
        end
    endtask
    task automatic set_pos(input int bx, by, rx, ry);
        Blue_X = 8'(bx);
        Blue_Y = 8'(by);
        Red_X  = 8'(rx);
        Red_Y  = 8'(ry);
    endtask
    task automatic push_trail(input int bx, by, rx, ry);
        int x, y, a;
        for (int i = 0; i < 8; i++) begin
            x = i < 4 ? bx : rx;
            y = i < 4 ? by : ry;
            a = (x + 8) * 2 + y * 1280 + ((i % 2) != 0 ? 320 : 0) + ((i / 2) % 2);
            sb.push_back({20'(a), i < 4 ? 16'h0001 : 16'h0003});
        end
    endtask
    task automatic test_reset;
        step(3);
        vectors += 6;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b, expected 0", mem_req); end
        if (mem_addr !== 20'd0) begin errors++; $display("FAIL reset_addr got %0d, expected 0", mem_addr); end
        if (mem_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h, expected 0", mem_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b, expected 0", busy); end
        if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b, expected 0", clear_done); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b, expected 0", overrun); end
        Reset = 1'b0;
        step(4);
    endtask
    task automatic test_trail_addresses;
        int n;
        logic [19:0] a[8] = '{20'd25636, 20'd25956, 20'd25637, 20'd25957,
                              20'd51276, 20'd51596, 20'd51277, 20'd51597};
        for (int i = 0; i < 8; i++) sb.push_back({a[i], i < 4 ? 16'h0001 : 16'h0003});
        mem_ack = 1'b1;
        Game_State = PLAY;
        set_pos(10, 20, 30, 40);
        frame_clk = 1'b1;
        wait_req("trail");
        wait_idle(n);
        frame_clk = 1'b0;
        step(4);
        vectors += 2;
        if (n !== 8) begin errors++; $display("FAIL trail_busy_cycles got %0d, expected 8", n); end
        if (sb.size() != 0) begin errors++; $display("FAIL trail_missing_writes got %0d left, expected 0", sb.size()); end
    endtask
    task automatic test_ack_stall;
        int n;
        mem_ack = 1'b0;
        set_pos(10, 20, 30, 40);
        push_trail(10, 20, 30, 40);
        frame_clk = 1'b1;
        wait_req("stall");
        frame_clk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mem_ack = 1'b1;
            vectors++;
            if (mem_addr !== 20'd25636 || mem_data !== 16'h0001) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got addr=%0d data=%h, expected addr=25636 data=0001", i, mem_addr, mem_data);
            end
            step(1);
        end
        vectors++;
        if (mem_addr !== 20'd25956) begin errors++; $display("FAIL stall_advance got addr=%0d, expected 25956", mem_addr); end
        wait_idle(n);
        step(3);
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL stall_missing_writes got %0d left, expected 0", sb.size()); end
    endtask
    task automatic test_not_play;
        int o0 = n_ovr;
        mem_ack = 1'b1;
        Game_State = 3'b001;
        frame_clk = 1'b1;
        step(8);
        frame_clk = 1'b0;
        vectors += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL not_play_busy got %b, expected 0", busy); end
        if (n_ovr != o0) begin errors++; $display("FAIL not_play_overrun got %0d pulses, expected 0", n_ovr - o0); end
        Game_State = PLAY;
        step(4);
    endtask
    task automatic test_clear;
        int n, o0 = n_ovr, d0 = n_done;
        mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back({20'(i), 16'h0000});
        clear_req = 1'b1;
        frame_clk = 1'b1;
        step(1);
        clear_req = 1'b0;
        wait_idle(n);
        vectors += 2;
        if (n !== 16) begin errors++; $display("FAIL clear_busy_cycles got %0d, expected 16", n); end
        if (clear_done !== 1'b1) begin errors++; $display("FAIL clear_done_timing got %b, expected 1", clear_done); end
        frame_clk = 1'b0;
        step(4);
        vectors += 3;
        if (n_done - d0 != 1) begin errors++; $display("FAIL clear_done_count got %0d, expected 1", n_done - d0); end
        if (n_ovr - o0 != 1) begin errors++; $display("FAIL clear_overrun_count got %0d, expected 1", n_ovr - o0); end
        if (sb.size() != 0) begin errors++; $display("FAIL clear_missing_writes got %0d left, expected 0", sb.size()); end
    endtask
    task automatic test_pending_overrun;
        int n, o0 = n_ovr;
        mem_ack = 1'b0;
        set_pos(10, 20, 30, 40);
        frame_clk = 1'b1;
        wait_req("pending");
        frame_clk = 1'b0;
        set_pos(0, 0, 255, 255);
        step(4);
        repeat (2) begin
            frame_clk = 1'b1;
            step(6);
            frame_clk = 1'b0;
            step(4);
        end
        vectors += 2;
        if (n_ovr - o0 != 1) begin errors++; $display("FAIL pending_overrun_count got %0d, expected 1", n_ovr - o0); end
        if (mem_addr !== 20'd25636) begin errors++; $display("FAIL pending_stalled_addr got %0d, expected 25636", mem_addr); end
        push_trail(10, 20, 30, 40);
        push_trail(0, 0, 255, 255);
        mem_ack = 1'b1;
        wait_idle(n);
        step(3);
        vectors += 2;
        if (n !== 16) begin errors++; $display("FAIL pending_busy_cycles got %0d, expected 16", n); end
        if (sb.size() != 0) begin errors++; $display("FAIL pending_missing_writes got %0d left, expected 0", sb.size()); end
    endtask
    task automatic test_clear_during_trail;
        int n, d0 = n_done;
        mem_ack = 1'b0;
        set_pos(10, 20, 30, 40);
        frame_clk = 1'b1;
        wait_req("clr_trail");
        frame_clk = 1'b0;
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(2);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 20'd25636) begin
            errors++;
            $display("FAIL clr_trail_hold got req=%b addr=%0d, expected req=1 addr=25636", mem_req, mem_addr);
        end
        sb.push_back({20'd25636, 16'h0001});
        for (int i = 0; i < 16; i++) sb.push_back({20'(i), 16'h0000});
        mem_ack = 1'b1;
        wait_idle(n);
        vectors += 2;
        if (n !== 17) begin errors++; $display("FAIL clr_trail_busy_cycles got %0d, expected 17", n); end
        if (clear_done !== 1'b1) begin errors++; $display("FAIL clr_trail_done got %b, expected 1", clear_done); end
        mem_ack = 1'b0;
        step(3);
        vectors += 2;
        if (n_done - d0 != 1) begin errors++; $display("FAIL clr_trail_done_count got %0d, expected 1", n_done - d0); end
        if (sb.size() != 0) begin errors++; $display("FAIL clr_trail_missing_writes got %0d left, expected 0", sb.size()); end
    endtask
    task automatic test_leave_play;
        mem_ack = 1'b0;
        set_pos(10, 20, 30, 40);
        sb.push_back({20'd25636, 16'h0001});
        sb.push_back({20'd25956, 16'h0001});
        sb.push_back({20'd25637, 16'h0001});
        frame_clk = 1'b1;
        wait_req("leave");
        frame_clk = 1'b0;
        mem_ack = 1'b1;
        step(2);
        mem_ack = 1'b0;
        Game_State = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 20'd25637) begin
                errors++;
                $display("FAIL leave_hold got req=%b addr=%0d, expected req=1 addr=25637", mem_req, mem_addr);
            end
        end
        mem_ack = 1'b1;
        step(1);
        vectors += 2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL leave_req got %b, expected 0", mem_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL leave_busy got %b, expected 0", busy); end
        step(5);
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL leave_missing_writes got %0d left, expected 0", sb.size()); end
        mem_ack = 1'b0;
        Game_State = PLAY;
        step(2);
    endtask
    task automatic test_reset_mid_clear;
        int d0 = n_done;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back({20'(i), 16'h0000});
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(5);
        Reset = 1'b1;
        step(1);
        vectors += 2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_clear_req got %b, expected 0", mem_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_clear_busy got %b, expected 0", busy); end
        Reset = 1'b0;
        step(20);
        vectors += 2;
        if (n_done != d0) begin errors++; $display("FAIL rst_clear_done got %0d pulses, expected 0", n_done - d0); end
        if (sb.size() != 0) begin errors++; $display("FAIL rst_clear_missing_writes got %0d left, expected 0", sb.size()); end
        mem_ack = 1'b0;
    endtask
    initial begin
        test_reset();
        test_trail_addresses();
        test_ack_stall();
        test_not_play();
        test_clear();
        test_pending_overrun();
        test_clear_during_trail();
        test_leave_play();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
